// File: rtl/bmp_stream_ctrl.sv
// bmp_stream_ctrl: emits a complete 24-bit BMP file (54-byte header, B,G,R pixels, row padding) as a byte stream
module bmp_stream_ctrl #(
  parameter int HRES = 512,
  parameter int VRES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);
  localparam int ROWB  = ((HRES * 3 + 3) / 4) * 4;
  localparam int PADN  = ROWB - HRES * 3;
  localparam int IMG   = ROWB * VRES;
  localparam int FSIZE = 54 + IMG;
  localparam logic [431:0] HDR_BYTES = {128'd0, 32'(IMG), 32'd0, 16'd24, 16'd1, 32'(VRES), 32'(HRES),
                                        32'd40, 32'd54, 32'd0, 32'(FSIZE), 16'h4D42};
  localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, PIX = 3'd2, PAD = 3'd3, DONE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [5:0]  hdr_q, hdr_d;
  logic [11:0] col_q, col_d, row_q, row_d;
  logic [1:0]  pad_q, pad_d, sel_q, sel_d;
  logic [23:0] hold_q, hold_d;
  logic        full_q, full_d;
  logic        acc, take, last_row, pix_end, pad_end;
  // col_q counts pixels captured in the row; the row's pixels are all out once byte R of pixel HRES goes
  assign last_row  = row_q == 12'(VRES - 1);
  assign pix_end   = state_q == PIX && sel_q == 2'd2 && col_q == 12'(HRES);
  assign pad_end   = state_q == PAD && pad_q == 2'(PADN - 1);
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign out_valid = state_q == HDR || state_q == PAD || (state_q == PIX && full_q);
  assign out_last  = last_row && ((pix_end && PADN == 0) || pad_end);
  assign out_data  = state_q == HDR ? HDR_BYTES[{hdr_q, 3'b000} +: 8] :
                     (state_q == PIX && full_q) ? (sel_q == 2'd0 ? hold_q[7:0] : sel_q == 2'd1 ? hold_q[15:8] : hold_q[23:16]) :
                     8'h00;
  assign acc       = out_valid && out_ready;
  // a new pixel may be taken in the same cycle the last byte of the held one is accepted
  assign pix_ready = state_q == PIX && (!full_q || (sel_q == 2'd2 && out_ready)) && col_q != 12'(HRES);
  assign take      = pix_valid && pix_ready;
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    col_d   = col_q;
    row_d   = row_q;
    pad_d   = pad_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    full_d  = full_q;
    if (state_q == IDLE ? start : (abort || state_q == DONE)) begin
      state_d = state_q == IDLE ? HDR : IDLE;
      hdr_d   = '0;
      col_d   = '0;
      row_d   = '0;
      pad_d   = '0;
      sel_d   = '0;
      full_d  = 1'b0;
    end else begin
      if (state_q == HDR && acc) begin
        hdr_d = hdr_q + 6'd1;
        if (hdr_q == 6'd53) state_d = PIX;
      end
      if (state_q == PIX && acc) begin
        sel_d = sel_q == 2'd2 ? 2'd0 : sel_q + 2'd1;
        if (sel_q == 2'd2) full_d = 1'b0;
      end
      if (take) begin
        hold_d = pix_data;
        full_d = 1'b1;
        col_d  = col_q + 12'd1;
      end
      if (state_q == PAD && acc) pad_d = pad_q + 2'd1;
      if (acc && ((pix_end && PADN == 0) || pad_end)) begin
        state_d = last_row ? DONE : PIX;
        row_d   = last_row ? row_q : row_q + 12'd1;
        col_d   = last_row ? col_q : 12'd0;
        pad_d   = 2'd0;
      end else if (acc && pix_end) begin
        state_d = PAD;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pad_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pad_q   <= pad_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
    end
  end
endmodule

// File: tb/tb_bmp_stream_ctrl.sv
// tb_bmp_stream_ctrl: directed vectors and file-level sequences for bmp_stream_ctrl
module tb_bmp_stream_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, abort = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] pix_data = '0;
  logic busy, done, pix_ready, out_valid, out_last;
  logic [7:0] out_data;
  logic s_start = 1'b0, s_abort = 1'b0, s_rdy = 1'b0;
  logic s_busy, s_done, s_pready, s_valid, s_last;
  logic [7:0] s_data;
  int vecs = 0, errs = 0;
  logic [7:0] exp_b [70];
  logic [23:0] pix [4];
  logic [7:0] h5 [14];
  typedef struct {
    logic st, ab, rdy;
    logic bsy, vld, lst, pr;
    logic [7:0] dat;
  } vec_t;
  vec_t tv [13];

  bmp_stream_ctrl #(.HRES(2), .VRES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

  bmp_stream_ctrl #(.HRES(512), .VRES(512)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .busy(s_busy), .done(s_done),
    .pix_valid(1'b0), .pix_ready(s_pready), .pix_data(24'h0),
    .out_valid(s_valid), .out_ready(s_rdy), .out_data(s_data), .out_last(s_last));

  task automatic chk(input string nm, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_pready"}, pix_ready, 0);
    chk({nm, "_data"}, out_data, 0);
  endtask

  task automatic run_file(input bit thr, input int abort_at);
    int n, pi, dn;
    bit stall;
    logic [7:0] sd;
    logic sl;
    n = 0; pi = 0; dn = 0; stall = 1'b0; sd = '0; sl = 1'b0;
    @(posedge clk); #1 start = 1'b1; abort = 1'b0; out_ready = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 3000 && dn == 0; cyc++) begin
      out_ready = thr ? ($urandom_range(0, 1) == 1) : 1'b1;
      pix_valid = pi < 4 && (!thr || $urandom_range(0, 1) == 1);
      pix_data  = pix[pi < 4 ? pi : 0];
      abort     = abort_at > 0 && n == abort_at;
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, sd);
        chk("stall_last", out_last, sl);
      end
      stall = out_valid && !out_ready;
      sd = out_data;
      sl = out_last;
      if (out_valid && out_ready) begin
        chk("byte", out_data, exp_b[n < 70 ? n : 0]);
        chk("last", out_last, n == 69 ? 1 : 0);
        n++;
      end
      if (pix_valid && pix_ready) pi++;
      if (done) dn++;
      if (abort) begin
        @(posedge clk); #1 abort = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pready", pix_ready, 0);
        chk("abort_done", done, 0);
        return;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    chk("done_count", dn, 1);
    chk("file_bytes", n, 70);
    chk("pixels_used", pi, 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_done_busy", busy, 0);
    chk("post_done_done", done, 0);
  endtask

  initial begin
    pix = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    h5  = '{8'h42, 8'h4D, 8'h36, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 70; i++) exp_b[i] = 8'h00;
    exp_b[0] = 8'h42; exp_b[1] = 8'h4D; exp_b[2] = 8'h46; exp_b[10] = 8'h36; exp_b[14] = 8'h28;
    exp_b[18] = 8'h02; exp_b[22] = 8'h02; exp_b[26] = 8'h01; exp_b[28] = 8'h18; exp_b[34] = 8'h10;
    exp_b[54] = 8'h33; exp_b[55] = 8'h22; exp_b[56] = 8'h11; exp_b[57] = 8'h66; exp_b[58] = 8'h55; exp_b[59] = 8'h44;
    exp_b[62] = 8'h99; exp_b[63] = 8'h88; exp_b[64] = 8'h77; exp_b[65] = 8'hCC; exp_b[66] = 8'hBB; exp_b[67] = 8'hAA;
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4D};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4D};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4D};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h46};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42};
    tv[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    @(negedge clk);
    chk_idle_outs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1 start = tv[i].st; abort = tv[i].ab; out_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("vec%0d_valid", i), out_valid, tv[i].vld);
      chk($sformatf("vec%0d_last", i), out_last, tv[i].lst);
      chk($sformatf("vec%0d_pready", i), pix_ready, tv[i].pr);
      chk($sformatf("vec%0d_done", i), done, 0);
      if (tv[i].vld) chk($sformatf("vec%0d_data", i), out_data, tv[i].dat);
    end
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    run_file(1'b0, 0);
    run_file(1'b1, 0);
    run_file(1'b1, 0);
    run_file(1'b0, 63);
    run_file(1'b0, 0);
    @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle_outs("mid_hdr_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    run_file(1'b1, 0);
    @(posedge clk); #1 s_start = 1'b1; s_rdy = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("hdr512_b%0d", i), s_data, h5[i]);
      chk("hdr512_valid", s_valid, 1);
      chk("hdr512_sig", {s_done, s_pready, s_last}, 0);
      @(posedge clk); #1;
    end
    s_abort = 1'b1;
    @(posedge clk); #1 s_abort = 1'b0;
    @(negedge clk);
    chk("hdr512_abort_busy", s_busy, 0);
    chk("hdr512_abort_valid", s_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
